bnn_xnor_neuron: RTL and testbench
==================================

// Module: bnn_xnor_neuron
// PURPOSE
//   Binary neuron stage of the BNN datapath, directly upstream of the top-level output register stage.
//   Accepts an input activation vector as N_BEATS serial beats of IN_W bits each (valid/ready).
//   XNORs each beat with its stored weight word and accumulates the popcount.
//   Compares the total with a programmable threshold; emits one binary activation (out_bit) plus the raw popcount.
// PARAMETERS
//   IN_W         8    activation/weight bits per beat
//   N_BEATS      4    beats per input vector (vector length = IN_W*N_BEATS = 32)
//   THR_DEFAULT  16   threshold value loaded at reset
//   (derived) CNT_W = clog2(IN_W*N_BEATS+1) = 6; AW = clog2(N_BEATS) = 2
// PORTS
//   clk        in   1      system clock, all state on rising edge
//   rst        in   1      synchronous reset, active-high
//   cfg_w_we   in   1      weight write strobe
//   cfg_addr   in   AW     weight word index (beat number)
//   cfg_data   in   IN_W   weight word; bit=1 means +1, bit=0 means -1
//   cfg_t_we   in   1      threshold write strobe
//   cfg_thr    in   CNT_W  threshold value
//   in_valid   in   1      input beat valid
//   in_data    in   IN_W   input activation bits
//   in_last    in   1      producer marks final beat of vector
//   in_ready   out  1      stage can accept a beat
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   out_bit    out  1      activation: 1 iff popcount >= threshold
//   out_pop    out  CNT_W  XNOR popcount of the full vector
//   err        out  1      sticky framing error (BNN_FRAME_CHECK_EN only, else 0)
// BEHAVIOUR
//   Reset values:
//     - state=ACCUM, beat=0, acc=0, weights=0, thr=THR_DEFAULT
//     - out_valid=0, out_bit=0, out_pop=0, err=0
//   States: ACCUM (in_ready=1), RESULT (in_ready=0); in_ready is decoded from the state register.
//   ACCUM: on in_valid&&in_ready:
//     - acc += popcount(~(in_data ^ w[beat])); beat++
//     - on the beat with beat==N_BEATS-1: next cycle go to RESULT with out_valid=1,
//       out_pop=final sum, out_bit=(sum>=thr)
//     - latency: result registered 1 cycle after the last beat is accepted
//   RESULT: out_valid/out_bit/out_pop held stable while out_ready=0.
//     - On out_valid&&out_ready: next cycle out_valid=0, acc=0, beat=0, state=ACCUM.
//     - min period per vector: N_BEATS+1 cycles
//   Arithmetic: acc is CNT_W bits and cannot overflow (max IN_W*N_BEATS); compare is unsigned.
//   Config:
//     - cfg_w_we honoured only in ACCUM with beat==0; otherwise ignored.
//     - cfg_t_we always honoured. A new threshold never alters an already-latched out_bit;
//       the compare uses thr as registered on the cycle the final beat is accepted.
//     - Both strobes in the same cycle are independent writes.
//     - A weight write coincident with the first accepted beat: the beat uses the old weight.
//   Beat counting: beat wraps N_BEATS-1 -> 0 on the final beat.
//   Reset mid-vector: partial acc/beat discarded; any pending result dropped; weights must be reloaded.
// CONFIGURATION
//   BNN_FRAME_CHECK_EN defined:
//     - err set (sticky until rst) if in_last=1 on an accepted beat other than N_BEATS-1,
//       or in_last=0 on accepted beat N_BEATS-1
//     - framing always follows the beat count, never in_last
//   Undefined: in_last ignored, err tied 0, no checker logic.
// STRUCTURE
//   bnn_pkg:
//     - state enum {ACCUM, RESULT}
//     - clog2 function; CNT_W/AW derivation
//     - BNN default constants (IN_W, N_BEATS, THR_DEFAULT)
//   Sub-module bnn_popcount #(W): purely combinational popcount of a W-bit word,
//   instantiated on the XNOR result.
// TESTING
//   1. Assert rst 2 cycles -> out_valid=0, in_ready=1, out_pop=0, err=0.
//   2. Weights 0xFF x4, thr=16, beats 0xFF x4 back-to-back
//      -> out_pop=32, out_bit=1, out_valid exactly 1 cycle after beat 4.
//   3. Weights 0xFF, beats 0x0F x4 -> out_pop=16, out_bit=1;
//      repeat with thr=17 -> out_bit=0; weights 0x00, beats 0x00 -> out_pop=32.
//   4. Hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, no beat consumed;
//      release -> first beat of next vector accepted the cycle after handshake.
//   5. rst after 2 beats, reload weights, send full vector -> result matches a fresh vector only.
//   6. With BNN_FRAME_CHECK_EN: in_last on beat 1 -> err=1 and stays 1; result still after beat 4.
//      Without the macro -> err=0.

Source files
------------

// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
//   Shared definitions for the binary-neuron datapath:
//     - state_t    : neuron stage states (ACCUM collects beats, RESULT holds
//                    the finished activation until the consumer takes it)
//     - clog2      : constant-evaluable ceil(log2(v)) used for width derivation
//     - BNN_*      : default geometry and threshold, plus derived widths
// ---------------------------------------------------------------------------
package bnn_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    // ceil(log2(v)); returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int BNN_IN_W        = 8;
    localparam int BNN_N_BEATS     = 4;
    localparam int BNN_THR_DEFAULT = 16;

    // Popcount of a full vector ranges 0..IN_W*N_BEATS inclusive.
    localparam int BNN_CNT_W = clog2(BNN_IN_W * BNN_N_BEATS + 1);
    localparam int BNN_AW    = clog2(BNN_N_BEATS);

endpackage

// File: rtl/bnn_popcount.sv
// ---------------------------------------------------------------------------
// bnn_popcount
//   Purely combinational population count of a W-bit word.
//   Ports:
//     din    in   W     word to count
//     count  out  PW    number of 1 bits in din (PW = clog2(W+1))
// ---------------------------------------------------------------------------
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int W  = 8,
    parameter int PW = clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [PW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + PW'(din[i]);
        end
    end

endmodule

// File: rtl/bnn_xnor_neuron.sv
// ---------------------------------------------------------------------------
// bnn_xnor_neuron
//   Binary neuron stage. An activation vector arrives as N_BEATS serial beats
//   of IN_W bits (valid/ready). Each beat is XNORed with its stored weight
//   word and the popcount is accumulated. After the last beat the total is
//   compared with a programmable threshold and one activation bit plus the
//   raw popcount are presented (valid/ready) and held until accepted.
//
//   Ports:
//     clk        in   1      system clock, rising edge
//     rst        in   1      synchronous reset, active-high
//     cfg_w_we   in   1      weight write strobe (only taken in ACCUM at beat 0)
//     cfg_addr   in   AW     weight word index (beat number)
//     cfg_data   in   IN_W   weight word, 1 = +1, 0 = -1
//     cfg_t_we   in   1      threshold write strobe (always taken)
//     cfg_thr    in   CNT_W  threshold value
//     in_valid   in   1      input beat valid
//     in_data    in   IN_W   input activation bits
//     in_last    in   1      producer's end-of-vector marker (checked only)
//     in_ready   out  1      stage can accept a beat
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer accepts result
//     out_bit    out  1      1 iff popcount >= threshold
//     out_pop    out  CNT_W  XNOR popcount of the full vector
//     err        out  1      sticky framing error
//
//   Build option: define BNN_FRAME_CHECK_EN to enable the in_last framing
//   checker driving err. Without it in_last is ignored and err is 0.
//   Framing always follows the internal beat count, never in_last.
// ---------------------------------------------------------------------------
module bnn_xnor_neuron
    import bnn_pkg::*;
#(
    parameter int IN_W        = BNN_IN_W,
    parameter int N_BEATS     = BNN_N_BEATS,
    parameter int THR_DEFAULT = BNN_THR_DEFAULT,
    parameter int CNT_W       = clog2(IN_W * N_BEATS + 1),
    parameter int AW          = clog2(N_BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_w_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [IN_W-1:0]  cfg_data,
    input  logic             cfg_t_we,
    input  logic [CNT_W-1:0] cfg_thr,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic [CNT_W-1:0] out_pop,
    output logic             err
);

    localparam int PW = clog2(IN_W + 1);
    localparam logic [AW-1:0] LAST_BEAT = AW'(N_BEATS - 1);

    state_t                        state_reg;
    logic [AW-1:0]                 beat_reg;
    logic [CNT_W-1:0]              acc_reg;
    logic [CNT_W-1:0]              thr_reg;
    logic                          out_valid_reg;
    logic                          out_bit_reg;
    logic [CNT_W-1:0]              out_pop_reg;
    logic [N_BEATS-1:0][IN_W-1:0]  w_reg;

    logic                          accept;
    logic                          final_beat;
    logic                          w_wr_open;
    logic [N_BEATS-1:0]            w_we;
    logic [IN_W-1:0]               xnor_word;
    logic [PW-1:0]                 beat_pop;
    logic [CNT_W-1:0]              acc_sum;

    assign in_ready   = (state_reg == ACCUM);
    assign accept     = in_valid && in_ready;
    assign final_beat = (beat_reg == LAST_BEAT);

    // Weights may only change between vectors so a vector never mixes old
    // and new weight words. A write coincident with the first accepted beat
    // lands after that beat has read the old word.
    assign w_wr_open  = (state_reg == ACCUM) && (beat_reg == '0);

    generate
        for (genvar gi = 0; gi < N_BEATS; gi++) begin : g_w_we
            assign w_we[gi] = cfg_w_we && w_wr_open && (cfg_addr == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            w_reg <= '0;
        end else begin
            for (int i = 0; i < N_BEATS; i++) begin
                if (w_we[i]) begin
                    w_reg[i] <= cfg_data;
                end
            end
        end
    end

    // XNOR counts agreements between activation and weight (+1*+1, -1*-1).
    assign xnor_word = ~(in_data ^ w_reg[beat_reg]);

    bnn_popcount #(
        .W  (IN_W),
        .PW (PW)
    ) u_popcount (
        .din   (xnor_word),
        .count (beat_pop)
    );

    // Cannot overflow: the sum is bounded by IN_W*N_BEATS.
    assign acc_sum = acc_reg + CNT_W'(beat_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ACCUM;
            beat_reg      <= '0;
            acc_reg       <= '0;
            thr_reg       <= CNT_W'(THR_DEFAULT);
            out_valid_reg <= 1'b0;
            out_bit_reg   <= 1'b0;
            out_pop_reg   <= '0;
        end else begin
            // The compare below reads thr_reg before this update takes
            // effect, so a coincident threshold write only affects later
            // vectors.
            if (cfg_t_we) begin
                thr_reg <= cfg_thr;
            end

            case (state_reg)
                ACCUM: begin
                    if (accept) begin
                        acc_reg <= acc_sum;
                        if (final_beat) begin
                            beat_reg      <= '0;
                            state_reg     <= RESULT;
                            out_valid_reg <= 1'b1;
                            out_pop_reg   <= acc_sum;
                            out_bit_reg   <= (acc_sum >= thr_reg);
                        end else begin
                            beat_reg <= beat_reg + AW'(1);
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        acc_reg       <= '0;
                        beat_reg      <= '0;
                        state_reg     <= ACCUM;
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

    assign out_valid = out_valid_reg;
    assign out_bit   = out_bit_reg;
    assign out_pop   = out_pop_reg;

`ifdef BNN_FRAME_CHECK_EN
    logic err_reg;

    // in_last must be asserted on exactly the final beat of each vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (accept && (in_last != final_beat)) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    wire unused_in_last;
    assign unused_in_last = in_last;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bnn_xnor_neuron.sv
// ---------------------------------------------------------------------------
// tb_bnn_xnor_neuron
//   Self-checking bench for bnn_xnor_neuron. A behavioural model tracks the
//   vector being assembled as plain arithmetic (sum of per-beat agreement
//   counts) and is compared against the DUT every cycle; a few directed
//   scenarios also pin literal values. Defining BNN_FRAME_CHECK_EN here too
//   switches the expected err behaviour.
// ---------------------------------------------------------------------------
module tb_bnn_xnor_neuron;

    localparam int IN_W    = 8;
    localparam int N_BEATS = 4;
    localparam int CNT_W   = 6;
    localparam int AW      = 2;
    localparam int THR_DEF = 16;

    logic             clk;
    logic             rst;
    logic             cfg_w_we;
    logic [AW-1:0]    cfg_addr;
    logic [IN_W-1:0]  cfg_data;
    logic             cfg_t_we;
    logic [CNT_W-1:0] cfg_thr;
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic [CNT_W-1:0] out_pop;
    logic             err;

    bnn_xnor_neuron dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_w_we  (cfg_w_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_t_we  (cfg_t_we),
        .cfg_thr   (cfg_thr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bit   (out_bit),
        .out_pop   (out_pop),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- behavioural model ----------------
    logic [IN_W-1:0] m_w [N_BEATS];
    int              m_thr;
    int              m_beat;       // beats of the current vector received
    int              m_sum;        // agreements counted so far
    bit              m_pend;       // a finished result awaits the consumer
    int              m_exp_pop;
    bit              m_exp_bit;
    bit              m_exp_err;
    bit              m_fresh;      // no result since reset: outputs at reset value
    bit              m_known = 0;  // DUT has seen at least one reset
    bit              m_acc;        // last edge accepted a beat
    bit              m_hs;         // last edge completed an output handshake
    int              m_results = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        if (m_known) begin
            chk("in_ready", int'(in_ready), int'(!m_pend));
            chk("out_valid", int'(out_valid), int'(m_pend));
            if (m_pend) begin
                chk("out_pop", int'(out_pop), m_exp_pop);
                chk("out_bit", int'(out_bit), int'(m_exp_bit));
            end else if (m_fresh) begin
                chk("out_pop_rst", int'(out_pop), 0);
                chk("out_bit_rst", int'(out_bit), 0);
            end
            chk("err", int'(err), int'(m_exp_err));
        end
    endtask

    // Apply the current input values to the model as the next edge will.
    task automatic update_model();
        bit              old_pend;
        int              old_beat;
        logic [IN_W-1:0] agree;
        m_acc = 0;
        m_hs  = 0;
        if (rst) begin
            for (int i = 0; i < N_BEATS; i++) m_w[i] = '0;
            m_thr     = THR_DEF;
            m_beat    = 0;
            m_sum     = 0;
            m_pend    = 0;
            m_exp_err = 0;
            m_fresh   = 1;
            m_known   = 1;
            return;
        end
        old_pend = m_pend;
        old_beat = m_beat;
        if (m_pend) begin
            if (out_ready) begin
                m_pend = 0;
                m_beat = 0;
                m_sum  = 0;
                m_hs   = 1;
            end
        end else if (in_valid) begin
            m_acc = 1;
            agree = ~(in_data ^ m_w[m_beat]);
            m_sum = m_sum + $countones(agree);
`ifdef BNN_FRAME_CHECK_EN
            if (in_last != (m_beat == N_BEATS - 1)) m_exp_err = 1;
`endif
            if (m_beat == N_BEATS - 1) begin
                m_pend    = 1;
                m_exp_pop = m_sum;
                m_exp_bit = (m_sum >= m_thr);
                m_fresh   = 0;
                m_beat    = 0;
                m_results++;
            end else begin
                m_beat++;
            end
        end
        if (cfg_w_we && !old_pend && old_beat == 0) m_w[cfg_addr] = cfg_data;
        if (cfg_t_we) m_thr = int'(cfg_thr);
    endtask

    // One clock: check at the falling edge, advance the model, return just
    // after the rising edge so the caller can drive the next inputs.
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        update_model();
        @(posedge clk);
        #1;
    endtask

    // Land between the rising edge and the next check for literal peeks.
    task automatic peek();
        #3;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        cfg_w_we  = 0; cfg_addr = '0; cfg_data = '0;
        cfg_t_we  = 0; cfg_thr  = '0;
        in_valid  = 0; in_data  = '0; in_last = 0;
    endtask

    task automatic write_w(input int addr, input logic [IN_W-1:0] data);
        cfg_w_we = 1; cfg_addr = AW'(addr); cfg_data = data;
        cycle();
        cfg_w_we = 0;
    endtask

    task automatic write_all_w(input logic [IN_W-1:0] data);
        for (int i = 0; i < N_BEATS; i++) write_w(i, data);
    endtask

    task automatic write_thr(input int v);
        cfg_t_we = 1; cfg_thr = CNT_W'(v);
        cycle();
        cfg_t_we = 0;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input bit last);
        int tries;
        in_valid = 1; in_data = d; in_last = last;
        tries = 0;
        do begin
            cycle();
            tries++;
        end while (!m_acc && tries < 50);
        if (!m_acc) chk("beat_accept_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic send_vec(input logic [IN_W-1:0] d, input logic [3:0] last_mask);
        for (int b = 0; b < N_BEATS; b++) send_beat(d, last_mask[b]);
    endtask

    task automatic wait_result();
        int tries;
        out_ready = 1;
        tries = 0;
        do begin
            cycle();
            tries++;
        end while (!m_hs && tries < 50);
        if (!m_hs) chk("result_timeout", 0, 1);
        out_ready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        out_ready = 0;
        rst = 1;

        // 1. reset
        cycle();
        cycle();
        rst = 0;
        peek();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_pop", int'(out_pop), 0);
        chk("rst_err", int'(err), 0);

        // 2. all agree -> 32, result visible right after final beat
        write_all_w(8'hFF);
        write_thr(16);
        send_vec(8'hFF, 4'b1000);
        peek();
        chk("t2_valid_after_last", int'(out_valid), 1);
        chk("t2_pop", int'(out_pop), 32);
        chk("t2_bit", int'(out_bit), 1);
        wait_result();

        // 3. half agree -> 16 at threshold boundary
        send_vec(8'h0F, 4'b1000);
        peek();
        chk("t3_pop16", int'(out_pop), 16);
        chk("t3_bit_thr16", int'(out_bit), 1);
        wait_result();
        write_thr(17);
        send_vec(8'h0F, 4'b1000);
        peek();
        chk("t3_bit_thr17", int'(out_bit), 0);
        wait_result();
        write_all_w(8'h00);
        send_vec(8'h00, 4'b1000);
        peek();
        chk("t3_pop_zero_w", int'(out_pop), 32);
        chk("t3_bit_zero_w", int'(out_bit), 1);

        // 4. backpressure: result held, no beat taken
        in_valid = 1; in_data = 8'h00; in_last = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            peek();
            chk("t4_stall_ready", int'(in_ready), 0);
            chk("t4_stall_pop", int'(out_pop), 32);
        end
        out_ready = 1;
        cycle();
        out_ready = 0;
        peek();
        chk("t4_ready_after_hs", int'(in_ready), 1);
        chk("t4_valid_after_hs", int'(out_valid), 0);
        send_beat(8'h00, 0);
        send_beat(8'h00, 0);
        send_beat(8'hFF, 0);
        send_beat(8'hFF, 1);
        peek();
        chk("t4_next_pop", int'(out_pop), 16);
        wait_result();

        // 5. reset mid-vector
        send_beat(8'h00, 0);
        send_beat(8'h00, 0);
        rst = 1;
        cycle();
        cycle();
        rst = 0;
        write_all_w(8'hFF);
        send_vec(8'h01, 4'b1000);
        peek();
        chk("t5_pop", int'(out_pop), 4);
        chk("t5_bit", int'(out_bit), 0);
        wait_result();

        // 6. framing checker
        send_vec(8'hFF, 4'b0001);
        peek();
        chk("t6_valid_after_beat4", int'(out_valid), 1);
        chk("t6_pop", int'(out_pop), 32);
`ifdef BNN_FRAME_CHECK_EN
        chk("t6_err_set", int'(err), 1);
`else
        chk("t6_err_off", int'(err), 0);
`endif
        wait_result();
        send_vec(8'hFF, 4'b1000);
        wait_result();
`ifdef BNN_FRAME_CHECK_EN
        chk("t6_err_sticky", int'(err), 1);
`else
        chk("t6_err_still_off", int'(err), 0);
`endif

        // 7. randomized traffic with config writes at arbitrary times
        rst = 1;
        cycle();
        rst = 0;
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = IN_W'($urandom);
            in_last   = (m_beat == N_BEATS - 1);
            if ($urandom_range(0, 49) == 0) in_last = !in_last;
            out_ready = $urandom_range(0, 1);
            cfg_w_we  = ($urandom_range(0, 7) == 0);
            cfg_addr  = AW'($urandom);
            cfg_data  = IN_W'($urandom);
            cfg_t_we  = ($urandom_range(0, 9) == 0);
            cfg_thr   = CNT_W'($urandom_range(0, 33));
            cycle();
        end
        idle_inputs();
        out_ready = 0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
